// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
//   Shared types and default timing for the push-button conditioner.
//   - btn_fsm_e : per-channel hold/repeat state machine encoding.
//   - DEF_*     : default cycle counts for a 50 MHz system clock.
//   Optional feature macro used by the consumers: BUTTON_AUTO_REPEAT_EN.
// -----------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE   = 2'd0,
        BTN_HELD   = 2'd1,
        BTN_REPEAT = 2'd2
    } btn_fsm_e;

    // 20 ms debounce, 500 ms long-press, 100 ms repeat at 50 MHz
    localparam int DEF_NUM_BUTTONS     = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_HOLD_CYCLES     = 25000000;
    localparam int DEF_REPEAT_CYCLES   = 5000000;

endpackage

// File: rtl/button_channel.sv
// -----------------------------------------------------------------------------
// button_channel
//   One push-button channel: 2-flop synchroniser, debouncer and hold/repeat FSM.
//   Optional macro BUTTON_AUTO_REPEAT_EN: when defined, the channel issues
//   auto-repeat pulses; when undefined, the repeat state and counter are absent
//   and btn_repeat is tied low (btn_long still works).
//
//   Ports
//     clk         in   system clock
//     rst         in   synchronous active-high reset
//     btn_raw_n   in   raw key, active-low, asynchronous to clk
//     btn_state   out  debounced level, 1 = pressed
//     btn_press   out  1-cycle pulse on accepted press
//     btn_release out  1-cycle pulse on accepted release
//     btn_repeat  out  1-cycle auto-repeat pulse
//     btn_long    out  level, key held past HOLD_CYCLES
// -----------------------------------------------------------------------------
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
`ifdef BUTTON_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_n,
    output logic btn_state,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat,
    output logic btn_long
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic              sync_p0, sync_p1;
    logic              key_down;
    logic [DB_W-1:0]   db_cnt;
    logic              state_q, press_q, release_q;
    logic              mismatch, db_done, accept_press, accept_release;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_tick;
    logic              long_q, long_nxt;
    btn_fsm_e          fsm_q, fsm_nxt;

    // ---- stage p0/p1: synchroniser, reset to the released (high) level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= btn_raw_n;
            sync_p1 <= sync_p0;
        end
    end

    assign key_down = ~sync_p1;

    // ---- debounce: count consecutive disagreeing cycles, accept on the last one
    assign mismatch       = (key_down != state_q);
    assign db_done        = mismatch && (db_cnt == DB_LAST);
    assign accept_press   = db_done && !state_q;
    assign accept_release = db_done && state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt    <= '0;
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            if (!mismatch || db_done)
                db_cnt <= '0;
            else
                db_cnt <= db_cnt + 1'b1;
            if (db_done)
                state_q <= ~state_q;
            press_q   <= accept_press;
            release_q <= accept_release;
        end
    end

    // Once btn_long is set in BTN_HELD the hold counter freezes, so without
    // auto-repeat the long level simply persists until release.
    assign hold_tick = (fsm_q == BTN_HELD) && !long_q && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst)
            hold_cnt <= '0;
        else if (fsm_q == BTN_IDLE || accept_release || hold_tick)
            hold_cnt <= '0;
        else if (fsm_q == BTN_HELD && !long_q)
            hold_cnt <= hold_cnt + 1'b1;
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_tick;
    logic             repeat_q, repeat_nxt;

    assign rep_tick = (fsm_q == BTN_REPEAT) && (rep_cnt == REP_LAST);

    always_ff @(posedge clk) begin
        if (rst)
            rep_cnt <= '0;
        else if (fsm_q != BTN_REPEAT || accept_release || rep_tick)
            rep_cnt <= '0;
        else
            rep_cnt <= rep_cnt + 1'b1;
    end
`endif

    // ---- FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            fsm_q <= BTN_IDLE;
        else
            fsm_q <= fsm_nxt;
    end

    // ---- FSM next state
    always_comb begin
        fsm_nxt = fsm_q;
        case (fsm_q)
            BTN_IDLE: begin
                if (accept_press)
                    fsm_nxt = BTN_HELD;
            end
            BTN_HELD: begin
                if (accept_release)
                    fsm_nxt = BTN_IDLE;
`ifdef BUTTON_AUTO_REPEAT_EN
                else if (hold_tick)
                    fsm_nxt = BTN_REPEAT;
`endif
            end
            BTN_REPEAT: begin
                if (accept_release)
                    fsm_nxt = BTN_IDLE;
            end
            default: fsm_nxt = BTN_IDLE;
        endcase
    end

    // ---- FSM outputs (next values, registered below); release beats a repeat tick
    always_comb begin
        long_nxt = long_q;
`ifdef BUTTON_AUTO_REPEAT_EN
        repeat_nxt = 1'b0;
`endif
        if (accept_release) begin
            long_nxt = 1'b0;
        end else if (hold_tick) begin
            long_nxt = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
            repeat_nxt = 1'b1;
        end else if (rep_tick) begin
            repeat_nxt = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            long_q <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
            repeat_q <= 1'b0;
`endif
        end else begin
            long_q <= long_nxt;
`ifdef BUTTON_AUTO_REPEAT_EN
            repeat_q <= repeat_nxt;
`endif
        end
    end

    assign btn_state   = state_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_long    = long_q;
`ifdef BUTTON_AUTO_REPEAT_EN
    assign btn_repeat  = repeat_q;
`else
    assign btn_repeat  = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Push-button front end for the alarm-clock SoC. Each raw active-low key is
//   synchronised, debounced and hold-timed by its own button_channel; btn_event
//   (press OR repeat) feeds the Qsys button PIO inputs.
//   Optional macro BUTTON_AUTO_REPEAT_EN enables auto-repeat pulses; without it
//   btn_repeat is 0 and btn_event equals btn_press.
//
//   Ports
//     clk_clk      in   system clock
//     reset_reset  in   synchronous active-high reset
//     btn_raw_n    in   raw keys, active-low, asynchronous
//     btn_state    out  debounced levels, 1 = pressed
//     btn_press    out  1-cycle press pulses
//     btn_release  out  1-cycle release pulses
//     btn_repeat   out  1-cycle auto-repeat pulses
//     btn_long     out  long-press levels
//     btn_event    out  btn_press | btn_repeat
// -----------------------------------------------------------------------------
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BUTTONS     = DEF_NUM_BUTTONS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic [NUM_BUTTONS-1:0] btn_raw_n,
    output logic [NUM_BUTTONS-1:0] btn_state,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release,
    output logic [NUM_BUTTONS-1:0] btn_repeat,
    output logic [NUM_BUTTONS-1:0] btn_long,
    output logic [NUM_BUTTONS-1:0] btn_event
);

    // The debouncer needs at least two cycles to tell a level from a glitch.
    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
        $error("button_conditioner: invalid cycle-count parameters");
    end

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES)
`ifdef BUTTON_AUTO_REPEAT_EN
            ,
            .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
        ) u_chan (
            .clk         (clk_clk),
            .rst         (reset_reset),
            .btn_raw_n   (btn_raw_n[i]),
            .btn_state   (btn_state[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_repeat  (btn_repeat[i]),
            .btn_long    (btn_long[i])
        );
    end

    assign btn_event = btn_press | btn_repeat;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    localparam int NB = 3;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] raw_n;
    logic [NB-1:0] btn_state, btn_press, btn_release, btn_repeat, btn_long, btn_event;

    int n_checks = 0;
    int n_fail   = 0;

    button_conditioner #(
        .NUM_BUTTONS     (NB),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .btn_raw_n   (raw_n),
        .btn_state   (btn_state),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat),
        .btn_long    (btn_long),
        .btn_event   (btn_event)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [NB-1:0] obs,
                       input logic [NB-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s edge %0d: observed %b expected %b", tag, k, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int k,
                           input logic [NB-1:0] st, input logic [NB-1:0] pr,
                           input logic [NB-1:0] rl, input logic [NB-1:0] rp,
                           input logic [NB-1:0] lg);
        chk({tag, ".state"},   k, btn_state,   st);
        chk({tag, ".press"},   k, btn_press,   pr);
        chk({tag, ".release"}, k, btn_release, rl);
        chk({tag, ".repeat"},  k, btn_repeat,  rp);
        chk({tag, ".long"},    k, btn_long,    lg);
        chk({tag, ".event"},   k, btn_event,   pr | rp);
    endtask

    initial begin
        logic a, b;

        // 1. reset with keys released
        rst   = 1'b1;
        raw_n = '1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk_all("t1_rst", k, '0, '0, '0, '0, '0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_all("t1_idle", k, '0, '0, '0, '0, '0);
        end

        // 2. short press on key 0: press at 6, release at 18
        raw_n[0] = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            step();
            a = (k >= 6 && k < 18);
            chk_all("t2", k, {2'b00, a}, {2'b00, k == 6}, {2'b00, k == 18}, '0, '0);
            if (k == 12) raw_n[0] = 1'b1;
        end

        // 3. glitch on key 1 shorter than the debounce window
        raw_n[1] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk_all("t3", k, '0, '0, '0, '0, '0);
            if (k == 3) raw_n[1] = 1'b1;
        end

        // 4. long hold on key 0: long at 26, repeats every 8 until release at 54
        raw_n[0] = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            step();
            a = (k >= 6 && k < 54);
            b = REP_EN && (k == 26 || k == 34 || k == 42 || k == 50);
            chk_all("t4", k, {2'b00, a}, {2'b00, k == 6}, {2'b00, k == 54},
                    {2'b00, b}, {2'b00, (k >= 26 && k < 54)});
            if (k == 48) raw_n[0] = 1'b1;
        end

        // 5. keys 0 and 2 together, key 1 silent
        raw_n = 3'b010;
        for (int k = 1; k <= 24; k++) begin
            step();
            a = (k >= 6 && k < 18);
            chk_all("t5", k, {a, 1'b0, a}, {k == 6, 1'b0, k == 6},
                    {k == 18, 1'b0, k == 18}, '0, '0);
            if (k == 12) raw_n = '1;
        end

        // 6. reset in the middle of a hold (sampled on edges 30..32)
        raw_n[0] = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            step();
            a = (k >= 6 && k < 30) || (k >= 38 && k < 46);
            b = REP_EN && (k == 26);
            chk_all("t6", k, {2'b00, a}, {2'b00, (k == 6 || k == 38)}, {2'b00, k == 46},
                    {2'b00, b}, {2'b00, (k >= 26 && k < 30)});
            if (k == 29) rst = 1'b1;
            if (k == 32) rst = 1'b0;
            if (k == 40) raw_n[0] = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
